kbd_joypad_bridge: RTL and testbench
====================================

// Module: kbd_joypad_bridge
// PURPOSE
//  Emulates two NES controllers (4021-style shift registers) from PS/2 keyboard scancodes.
//  Upstream: byte-level PS/2 receiver in the same clock domain.
//  Downstream: rp2a03 joypad pins (jp_clk/jp_latch in, jp_data1/2 out) and the top-level
//  console-reset / cart-reset controls.
//  Replaces the logic currently inside the keyboard block.
// PARAMETERS
//  DATA_ACTIVE_LOW  1  1: pressed button drives jp_dataN low (real 4021 level); 0: pressed = high
//  BLOCK_OPPOSITE   1  1: Up+Down or Left+Right both held -> both read released at latch time
// PORTS
//  clk_in           in   1  system clock (CLK_100MHZ)
//  rst_in           in   1  synchronous reset, active-high
//  scan_code_in     in   8  PS/2 byte from receiver
//  scan_valid_in    in   1  one-cycle strobe, scan_code_in valid
//  jp_clk_in        in   1  controller shift clock from rp2a03 (level, clk_in-synchronous)
//  jp_latch_in      in   1  controller latch/strobe from rp2a03
//  jp_data1_out     out  1  player-1 serial data
//  jp_data2_out     out  1  player-2 serial data
//  btn1_out         out  8  player-1 held buttons, active-high (debug/HCI)
//  btn2_out         out  8  player-2 held buttons, active-high
//  key_reset_out    out  1  high while F12 (0x07) is held
//  key_cart_out     out  1  high while F11 (0x78) is held
// BEHAVIOUR
//  Button bit order 0..7: A, B, Select, Start, Up, Down, Left, Right.
//  Map P1 (make codes): X=22 Z=1A Tab=0D Enter=5A; E0+75 Up, E0+72 Down, E0+6B Left, E0+74 Right.
//  Map P2 (make codes): K=42 J=3B U=3C I=43 W=1D S=1B A=1C D=23.
//  Arrow codes without E0, and letter codes with E0, are ignored.
//  Prefix FSM (advances only on scan_valid_in):
//   IDLE   : E0->EXT; F0->BRK; mapped code -> set bit, stay IDLE; other codes (incl. E1/AA/FA/EE) ignored
//   EXT    : F0->EXT_BRK; code -> set ext-mapped bit, ->IDLE
//   BRK    : code -> clear bit, ->IDLE
//   EXT_BRK: code -> clear ext-mapped bit, ->IDLE
//   In any non-IDLE state, an unmapped code returns to IDLE with no change.
//   E0 received in EXT/BRK restarts at EXT.
//  Repeated make codes (typematic) are idempotent.
//  Shift regs sr1/sr2 (8b) hold output levels; jp_dataN_out = srN[0].
//  Load value: lv = DATA_ACTIVE_LOW ? ~btn_masked : btn_masked.
//  While jp_latch_in==1: srN <= lv every cycle (transparent).
//   Any jp_clk edge during latch is ignored (load wins).
//  Rising edge of jp_clk_in: jclk_q registered; edge = jp_clk_in & ~jclk_q.
//   With latch low: srN <= {1'b1, srN[7:1]}. Output changes on the cycle after the edge.
//   After 8 shifts the line reads 1 indefinitely (until next latch).
//  btn_masked uses btnN registers as of the cycle the load happens.
//   A scancode accepted in the same cycle is visible at the next load cycle.
//  BLOCK_OPPOSITE applies only to load values; btnN_out is unmasked.
//  Reset: FSM=IDLE, btn1/btn2=0, sr1/sr2=8'hFF, jclk_q=0.
//   jp_data*=1, key_reset_out=0, key_cart_out=0.
//   Reset mid-sequence discards any pending prefix.
// STRUCTURE
//  Shared package nes_kbd_pkg:
//   - button index localparams (BTN_A..BTN_RIGHT)
//   - scancode constants (SC_E0, SC_F0, per-key codes)
//   - FSM state encoding
//  One sub-module, jp_shift_reg (latch/edge/shift, one instance per player).
//  The decoder stays in this module.
// TESTING
//  1 Reset only -> jp_data1/2=1, btn1/2=0, keys=0.
//  2 Bytes 22, then latch pulse -> jp_data1=0; then 7 jp_clk edges -> 1,1,1,1,1,1,1; 9th read = 1.
//  3 E0 75, E0 72, latch, 4 clks -> Up/Down masked: bit4=1, bit5=1.
//     With BLOCK_OPPOSITE=0 -> bits 4/5 read 0.
//  4 1C held, then F0 1C -> btn2_out 8'h40 -> 8'h00.
//     Latch afterwards -> jp_data2 shows all 1s.
//  5 Scan strobe (5A) same cycle as latch-high first cycle -> Start absent on that load.
//     Present on the following load cycle.
//  6 E0 F0, rst_in 1 cycle, then 74 -> treated as unprefixed make: ignored; btn1_out stays 0.
//  7 07 -> key_reset_out=1 next cycle; F0 07 -> 0.

Source files
------------

// File: rtl/nes_kbd_pkg.sv
// Shared constants, scancode decode and button masking for the PS/2-to-NES joypad bridge.
package nes_kbd_pkg;

  localparam int unsigned BTN_W     = 8;
  localparam int unsigned BTN_A     = 0;
  localparam int unsigned BTN_B     = 1;
  localparam int unsigned BTN_SEL   = 2;
  localparam int unsigned BTN_START = 3;
  localparam int unsigned BTN_UP    = 4;
  localparam int unsigned BTN_DOWN  = 5;
  localparam int unsigned BTN_LEFT  = 6;
  localparam int unsigned BTN_RIGHT = 7;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_X     = 8'h22;
  localparam logic [7:0] SC_Z     = 8'h1A;
  localparam logic [7:0] SC_TAB   = 8'h0D;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_K     = 8'h42;
  localparam logic [7:0] SC_J     = 8'h3B;
  localparam logic [7:0] SC_U     = 8'h3C;
  localparam logic [7:0] SC_I     = 8'h43;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_F12   = 8'h07;
  localparam logic [7:0] SC_F11   = 8'h78;

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_e;
  typedef enum logic [1:0] {DST_P1, DST_P2, DST_RESET, DST_CART} dst_e;

  typedef struct packed {
    logic       hit;
    dst_e       dst;
    logic [2:0] idx;
  } key_sel_t;

  // Codes that are meaningful without an E0 prefix.
  function automatic key_sel_t decode_plain(input logic [7:0] code);
    key_sel_t k;
    k.hit = 1'b1;
    k.dst = DST_P1;
    k.idx = 3'(BTN_A);
    case (code)
      SC_X:     k.idx = 3'(BTN_A);
      SC_Z:     k.idx = 3'(BTN_B);
      SC_TAB:   k.idx = 3'(BTN_SEL);
      SC_ENTER: k.idx = 3'(BTN_START);
      SC_K:     begin k.dst = DST_P2; k.idx = 3'(BTN_A);     end
      SC_J:     begin k.dst = DST_P2; k.idx = 3'(BTN_B);     end
      SC_U:     begin k.dst = DST_P2; k.idx = 3'(BTN_SEL);   end
      SC_I:     begin k.dst = DST_P2; k.idx = 3'(BTN_START); end
      SC_W:     begin k.dst = DST_P2; k.idx = 3'(BTN_UP);    end
      SC_S:     begin k.dst = DST_P2; k.idx = 3'(BTN_DOWN);  end
      SC_A:     begin k.dst = DST_P2; k.idx = 3'(BTN_LEFT);  end
      SC_D:     begin k.dst = DST_P2; k.idx = 3'(BTN_RIGHT); end
      SC_F12:   k.dst = DST_RESET;
      SC_F11:   k.dst = DST_CART;
      default:  k.hit = 1'b0;
    endcase
    return k;
  endfunction

  // Codes that are meaningful only after an E0 prefix (player-1 arrows).
  function automatic key_sel_t decode_ext(input logic [7:0] code);
    key_sel_t k;
    k.hit = 1'b1;
    k.dst = DST_P1;
    k.idx = 3'(BTN_UP);
    case (code)
      SC_UP:    k.idx = 3'(BTN_UP);
      SC_DOWN:  k.idx = 3'(BTN_DOWN);
      SC_LEFT:  k.idx = 3'(BTN_LEFT);
      SC_RIGHT: k.idx = 3'(BTN_RIGHT);
      default:  k.hit = 1'b0;
    endcase
    return k;
  endfunction

  function automatic logic [BTN_W-1:0] mask_opposite(input logic [BTN_W-1:0] btn, input logic en);
    logic [BTN_W-1:0] m;
    m = btn;
    if (en && btn[BTN_UP] && btn[BTN_DOWN]) begin
      m[BTN_UP]   = 1'b0;
      m[BTN_DOWN] = 1'b0;
    end
    if (en && btn[BTN_LEFT] && btn[BTN_RIGHT]) begin
      m[BTN_LEFT]  = 1'b0;
      m[BTN_RIGHT] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/jp_shift_reg.sv
// 4021-style controller shift register: transparent load while latched,
// shift toward bit 0 on each rising jp_clk edge, refilling with 1s.
module jp_shift_reg
  import nes_kbd_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             latch_i,
  input  logic             jclk_i,
  input  logic [BTN_W-1:0] load_val_i,
  output logic             data_o
);

  logic [BTN_W-1:0] sr_q, sr_d;
  logic             jclk_q;
  logic             edge_c;

  assign edge_c = jclk_i & ~jclk_q;

  // Load has priority over any clock edge seen while latched.
  always_comb begin
    sr_d = sr_q;
    if (latch_i) begin
      sr_d = load_val_i;
    end else if (edge_c) begin
      sr_d = {1'b1, sr_q[BTN_W-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q   <= '1;
      jclk_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      jclk_q <= jclk_i;
    end
  end

  assign data_o = sr_q[0];

endmodule

// File: rtl/kbd_joypad_bridge.sv
// PS/2 scancode decoder driving two emulated NES controllers plus
// console-reset and cart-reset hold keys.
module kbd_joypad_bridge
  import nes_kbd_pkg::*;
#(
  parameter bit DATA_ACTIVE_LOW = 1'b1,
  parameter bit BLOCK_OPPOSITE  = 1'b1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [7:0]       scan_code_in,
  input  logic             scan_valid_in,
  input  logic             jp_clk_in,
  input  logic             jp_latch_in,
  output logic             jp_data1_out,
  output logic             jp_data2_out,
  output logic [BTN_W-1:0] btn1_out,
  output logic [BTN_W-1:0] btn2_out,
  output logic             key_reset_out,
  output logic             key_cart_out
);

  state_e           state_q, state_d;
  logic [BTN_W-1:0] btn1_q, btn1_d, btn2_q, btn2_d;
  logic             key_rst_q, key_rst_d, key_cart_q, key_cart_d;
  key_sel_t         ksel;
  logic             make;
  logic [BTN_W-1:0] lv1, lv2;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      btn1_q     <= '0;
      btn2_q     <= '0;
      key_rst_q  <= 1'b0;
      key_cart_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn1_q     <= btn1_d;
      btn2_q     <= btn2_d;
      key_rst_q  <= key_rst_d;
      key_cart_q <= key_cart_d;
    end
  end

  // Prefix decode; ksel.hit only rises on a final (non-prefix) byte.
  always_comb begin
    state_d    = state_q;
    btn1_d     = btn1_q;
    btn2_d     = btn2_q;
    key_rst_d  = key_rst_q;
    key_cart_d = key_cart_q;
    ksel       = '0;
    make       = 1'b0;
    if (scan_valid_in) begin
      unique case (state_q)
        ST_IDLE: begin
          if (scan_code_in == SC_E0)      state_d = ST_EXT;
          else if (scan_code_in == SC_F0) state_d = ST_BRK;
          else begin
            ksel = decode_plain(scan_code_in);
            make = 1'b1;
          end
        end
        ST_EXT: begin
          if (scan_code_in == SC_F0)      state_d = ST_EXT_BRK;
          else if (scan_code_in == SC_E0) state_d = ST_EXT;
          else begin
            ksel    = decode_ext(scan_code_in);
            make    = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (scan_code_in == SC_E0) state_d = ST_EXT;
          else begin
            ksel    = decode_plain(scan_code_in);
            state_d = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          ksel    = decode_ext(scan_code_in);
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (ksel.hit) begin
      unique case (ksel.dst)
        DST_P1:    btn1_d[ksel.idx] = make;
        DST_P2:    btn2_d[ksel.idx] = make;
        DST_RESET: key_rst_d        = make;
        DST_CART:  key_cart_d       = make;
        default:   ;
      endcase
    end
  end

  always_comb begin
    lv1 = mask_opposite(btn1_q, BLOCK_OPPOSITE);
    lv2 = mask_opposite(btn2_q, BLOCK_OPPOSITE);
    if (DATA_ACTIVE_LOW) begin
      lv1 = ~lv1;
      lv2 = ~lv2;
    end
  end

  jp_shift_reg u_sr1 (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .latch_i    (jp_latch_in),
    .jclk_i     (jp_clk_in),
    .load_val_i (lv1),
    .data_o     (jp_data1_out)
  );

  jp_shift_reg u_sr2 (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .latch_i    (jp_latch_in),
    .jclk_i     (jp_clk_in),
    .load_val_i (lv2),
    .data_o     (jp_data2_out)
  );

  assign btn1_out      = btn1_q;
  assign btn2_out      = btn2_q;
  assign key_reset_out = key_rst_q;
  assign key_cart_out  = key_cart_q;

endmodule

// File: tb/tb_kbd_joypad_bridge.sv
// Directed and randomized check of kbd_joypad_bridge against a key-table /
// bit-stream reference model.
module tb_kbd_joypad_bridge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic       jclk = 1'b0;
  logic       latch = 1'b0;
  logic       d1, d2, krst, kcart;
  logic [7:0] b1, b2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  kbd_joypad_bridge dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .scan_code_in  (scan_code),
    .scan_valid_in (scan_valid),
    .jp_clk_in     (jclk),
    .jp_latch_in   (latch),
    .jp_data1_out  (d1),
    .jp_data2_out  (d2),
    .btn1_out      (b1),
    .btn2_out      (b2),
    .key_reset_out (krst),
    .key_cart_out  (kcart)
  );

  // Reference model state.
  bit [7:0] m_btn [2];
  bit       m_rst, m_cart;
  bit       pend_e0, pend_f0;
  bit [7:0] m_levels [2];
  int       m_shifts [2];
  bit       m_prev_jclk;

  // Returns player (0/1), 2 = reset key, 3 = cart key, -1 = not a key.
  function automatic int lookup(input bit ext, input bit [7:0] c, output int bit_no);
    bit_no = 0;
    if (ext) begin
      case (c)
        8'h75: begin bit_no = 4; return 0; end
        8'h72: begin bit_no = 5; return 0; end
        8'h6B: begin bit_no = 6; return 0; end
        8'h74: begin bit_no = 7; return 0; end
        default: return -1;
      endcase
    end
    case (c)
      8'h22: begin bit_no = 0; return 0; end
      8'h1A: begin bit_no = 1; return 0; end
      8'h0D: begin bit_no = 2; return 0; end
      8'h5A: begin bit_no = 3; return 0; end
      8'h42: begin bit_no = 0; return 1; end
      8'h3B: begin bit_no = 1; return 1; end
      8'h3C: begin bit_no = 2; return 1; end
      8'h43: begin bit_no = 3; return 1; end
      8'h1D: begin bit_no = 4; return 1; end
      8'h1B: begin bit_no = 5; return 1; end
      8'h1C: begin bit_no = 6; return 1; end
      8'h23: begin bit_no = 7; return 1; end
      8'h07: return 2;
      8'h78: return 3;
      default: return -1;
    endcase
  endfunction

  // Level the controller presents for each button at load time (pressed = 0).
  function automatic bit [7:0] levels_of(input bit [7:0] held);
    bit [7:0] h = held;
    if (h[4] && h[5]) begin h[4] = 0; h[5] = 0; end
    if (h[6] && h[7]) begin h[6] = 0; h[7] = 0; end
    return ~h;
  endfunction

  task automatic model_edge(input bit sv, input bit [7:0] sc, input bit lt, input bit jc, input bit rs);
    int who, bn;
    if (rs) begin
      m_btn[0] = 0; m_btn[1] = 0; m_rst = 0; m_cart = 0;
      pend_e0 = 0; pend_f0 = 0; m_prev_jclk = 0;
      for (int p = 0; p < 2; p++) begin m_levels[p] = 8'hFF; m_shifts[p] = 0; end
      return;
    end
    for (int p = 0; p < 2; p++) begin
      if (lt) begin
        m_levels[p] = levels_of(m_btn[p]);
        m_shifts[p] = 0;
      end else if (jc && !m_prev_jclk && m_shifts[p] < 8) begin
        m_shifts[p]++;
      end
    end
    m_prev_jclk = jc;
    if (sv) begin
      if (sc == 8'hE0 && !(pend_e0 && pend_f0)) begin
        pend_e0 = 1; pend_f0 = 0;
      end else if (sc == 8'hF0 && !pend_f0) begin
        pend_f0 = 1;
      end else begin
        who = lookup(pend_e0, sc, bn);
        case (who)
          0, 1: m_btn[who][bn] = !pend_f0;
          2: m_rst  = !pend_f0;
          3: m_cart = !pend_f0;
          default: ;
        endcase
        pend_e0 = 0; pend_f0 = 0;
      end
    end
  endtask

  function automatic bit exp_data(input int p);
    if (m_shifts[p] >= 8) return 1'b1;
    return m_levels[p][m_shifts[p]];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic tick(input bit sv, input bit [7:0] sc, input bit lt, input bit jc, input bit rs);
    scan_valid = sv; scan_code = sc; latch = lt; jclk = jc; rst = rs;
    @(posedge clk);
    model_edge(sv, sc, lt, jc, rs);
    #1;
    chk("data1", 8'(d1), 8'(exp_data(0)));
    chk("data2", 8'(d2), 8'(exp_data(1)));
    chk("btn1", b1, m_btn[0]);
    chk("btn2", b2, m_btn[1]);
    chk("key_reset", 8'(krst), 8'(m_rst));
    chk("key_cart", 8'(kcart), 8'(m_cart));
  endtask

  task automatic key(input bit [7:0] sc);
    tick(1, sc, 0, 0, 0);
  endtask

  task automatic idle();
    tick(0, 8'h00, 0, 0, 0);
  endtask

  task automatic pulse_latch();
    tick(0, 8'h00, 1, 0, 0);
  endtask

  task automatic pulse_jclk();
    tick(0, 8'h00, 0, 1, 0);
    idle();
  endtask

  initial begin
    bit [7:0] pool [20];
    bit [7:0] c;
    pool = '{8'h22, 8'h1A, 8'h0D, 8'h5A, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h42, 8'h3B,
             8'h3C, 8'h43, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h07, 8'h78, 8'hE0, 8'hF0};

    // Reset values.
    tick(0, 8'h00, 0, 0, 1);
    tick(0, 8'h00, 0, 0, 1);
    chk("rst_data1", 8'(d1), 8'h01);
    chk("rst_btn1", b1, 8'h00);
    idle();

    // X held, latch, read A then seven 1s, plus one past the end.
    key(8'h22);
    pulse_latch();
    idle();
    chk("x_first_bit", 8'(d1), 8'h00);
    for (int i = 0; i < 8; i++) pulse_jclk();
    chk("x_after_8", 8'(d1), 8'h01);
    key(8'hF0); key(8'h22);

    // Up+Down held: both read released.
    key(8'hE0); key(8'h75); key(8'hE0); key(8'h72);
    chk("updown_btn1", b1, 8'h30);
    pulse_latch();
    for (int i = 0; i < 4; i++) pulse_jclk();
    chk("up_masked", 8'(d1), 8'h01);
    pulse_jclk();
    chk("down_masked", 8'(d1), 8'h01);
    key(8'hE0); key(8'hF0); key(8'h75);
    key(8'hE0); key(8'hF0); key(8'h72);

    // Player-2 Left press/release.
    key(8'h1C);
    chk("p2_left_held", b2, 8'h40);
    key(8'hF0); key(8'h1C);
    chk("p2_left_rel", b2, 8'h00);
    pulse_latch();
    for (int i = 0; i < 8; i++) pulse_jclk();

    // Enter strobed on the first latch cycle misses that load.
    tick(1, 8'h5A, 1, 0, 0);
    for (int i = 0; i < 3; i++) pulse_jclk();
    chk("start_absent", 8'(d1), 8'h01);
    pulse_latch();
    for (int i = 0; i < 3; i++) pulse_jclk();
    chk("start_present", 8'(d1), 8'h00);
    key(8'hF0); key(8'h5A);

    // Reset discards pending E0 F0 prefix.
    key(8'hE0); key(8'hF0);
    tick(0, 8'h00, 0, 0, 1);
    key(8'h74);
    chk("prefix_dropped", b1, 8'h00);

    // F12 / F11 hold keys.
    key(8'h07);
    chk("f12_make", 8'(krst), 8'h01);
    key(8'hF0); key(8'h07);
    chk("f12_break", 8'(krst), 8'h00);
    key(8'h78); key(8'hF0); key(8'h78);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      c = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 19)];
      tick(($urandom_range(0, 2) == 0), c, ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 299) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
